// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
//   state_e           : sequencer states (clear after reset, idle/fetch, byte-serial load)
//   BYTES_PER_WORD    : bytes per instruction word for the default 32-bit width
//   FILL_INSTR_DEFAULT: MIPS nop, written during clear and returned for unmapped fetches
package imem_pkg;

  typedef enum logic [1:0] {StClear, StIdle, StLoad} state_e;

  localparam int unsigned DATA_W_DEFAULT     = 32;
  localparam int unsigned BYTES_PER_WORD     = DATA_W_DEFAULT / 8;
  localparam logic [31:0] FILL_INSTR_DEFAULT = 32'h0000_0000;

  function automatic int unsigned bytes_per_word(int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Fetch and load bus of the instruction memory.
//   master: processor fetch side plus the UART/switch loader (drives requests and bytes)
//   slave : the memory (returns fetch data and load status)
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_valid;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              busy;
  logic              ld_error;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output fetch_req, fetch_addr, ld_start, ld_base, ld_valid, ld_byte, ld_last,
    input  fetch_instr, fetch_valid, busy, ld_error, ld_count
  );

  modport slave (
    input  fetch_req, fetch_addr, ld_start, ld_base, ld_valid, ld_byte, ld_last,
    output fetch_instr, fetch_valid, busy, ld_error, ld_count
  );
endinterface

// File: rtl/imem_byte_assembler.sv
// Packs MSB-first load bytes into instruction words.
//   clk, reset : clock, synchronous active-low reset
//   clr        : drop any partial word (held while not loading)
//   ld_valid   : ld_byte is valid this cycle
//   ld_byte    : incoming byte
//   word       : assembled word including the current byte (valid with word_done)
//   word_done  : current byte completes a word
module imem_byte_assembler
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  localparam int unsigned Bpw  = bytes_per_word(DATA_W);
  localparam int unsigned CntW = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic [CntW-1:0] byte_cnt_q;

  assign word_done = ld_valid && (byte_cnt_q == CntW'(Bpw - 1));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      byte_cnt_q <= '0;
    end else if (ld_valid) begin
      byte_cnt_q <= word_done ? '0 : byte_cnt_q + 1'b1;
    end
  end

  generate
    if (DATA_W > 8) begin : g_shift
      // Holds the earlier bytes of the word; the newest byte is appended combinationally.
      logic [DATA_W-9:0] asm_q;
      assign word = {asm_q, ld_byte};
      always_ff @(posedge clk) begin
        if (ld_valid) asm_q <= word[DATA_W-9:0];
      end
    end else begin : g_single
      assign word = ld_byte;
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Run-time loadable instruction memory with a 1-cycle registered fetch port.
//   clk, reset : clock, synchronous active-low reset
//   bus (slave): fetch_req/fetch_addr -> fetch_instr/fetch_valid next cycle;
//                ld_start/ld_base/ld_valid/ld_byte/ld_last byte-serial load;
//                busy (clear or load), ld_error (sticky), ld_count (words written)
// After reset the array is wiped to FILL_INSTR over DEPTH cycles before fetches are served.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned DATA_W        = 32,
  parameter logic [DATA_W-1:0] FILL_INSTR = DATA_W'(FILL_INSTR_DEFAULT)
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [ADDR_W:0]     wr_ptr_q;   // one extra bit so overflow past the top never wraps
  logic [DATA_W-1:0]   fetch_instr_q;
  logic                fetch_valid_q;
  logic                busy_q;
  logic                ld_error_q;
  logic [ADDR_W:0]     ld_count_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                asm_valid;
  logic [DATA_W-1:0]   asm_word;
  logic                asm_done;
  logic                wr_in_range;
  logic                fetch_in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign asm_valid = (state_q == StLoad) && bus.ld_valid;

  imem_byte_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_q != StLoad),
    .ld_valid  (asm_valid),
    .ld_byte   (bus.ld_byte),
    .word      (asm_word),
    .word_done (asm_done)
  );

  assign wr_in_range    = wr_ptr_q < (ADDR_W+1)'(DEPTH);
  assign fetch_in_range = {1'b0, bus.fetch_addr} < (ADDR_W+1)'(DEPTH);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = FILL_INSTR;
    if (reset) begin
      if (state_q == StClear) begin
        mem_we = 1'b1;
      end else if (state_q == StLoad && asm_done && wr_in_range) begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr_q[ADDR_W-1:0];
        mem_wdata = asm_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StClear;
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= FILL_INSTR;
      busy_q        <= 1'b1;
      ld_error_q    <= 1'b0;
      ld_count_q    <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          fetch_valid_q <= 1'b0;
          if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        StIdle: begin
          if (bus.ld_start) begin
            // A same-cycle fetch is dropped in favour of the load.
            state_q       <= StLoad;
            busy_q        <= 1'b1;
            wr_ptr_q      <= {1'b0, bus.ld_base};
            ld_count_q    <= '0;
            ld_error_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
          end else if (bus.fetch_req) begin
            fetch_valid_q <= 1'b1;
            fetch_instr_q <= fetch_in_range ? mem_q[bus.fetch_addr] : FILL_INSTR;
          end else begin
            fetch_valid_q <= 1'b0;
          end
        end
        StLoad: begin
          fetch_valid_q <= 1'b0;
          if (asm_done) begin
            if (wr_in_range) begin
              wr_ptr_q   <= wr_ptr_q + 1'b1;
              ld_count_q <= ld_count_q + 1'b1;
            end else begin
              ld_error_q <= 1'b1;
            end
          end
          if (asm_valid && bus.ld_last) begin
            if (!asm_done) ld_error_q <= 1'b1;  // partial word discarded
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign bus.fetch_instr = fetch_instr_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.busy        = busy_q;
  assign bus.ld_error    = ld_error_q;
  assign bus.ld_count    = ld_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear, load/fetch, partial word, overflow,
// start/fetch priority and reset during a load.
module tb_imem_loader;

  localparam int unsigned AddrW = 6;
  localparam int unsigned Depth = 64;
  localparam int unsigned DataW = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  imem_loader_if #(.ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  imem_loader #(
    .ADDR_W     (AddrW),
    .DEPTH      (Depth),
    .DATA_W     (DataW),
    .FILL_INSTR (32'h0000_0000)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts cycles while busy after reset release; bounded.
  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (bus.busy && cnt < 200);
    check_eq(tag, 64'(cnt), 64'(Depth));
  endtask

  task automatic fetch(input string tag, input logic [AddrW-1:0] addr,
                       input logic [31:0] exp);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    step();
    bus.fetch_req = 1'b0;
    check_eq({tag, "_valid"}, 64'(bus.fetch_valid), 64'd1);
    check_eq({tag, "_instr"}, 64'(bus.fetch_instr), 64'(exp));
  endtask

  task automatic start_load(input logic [AddrW-1:0] base);
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    step();
    bus.ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    step();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  logic [7:0] prog [8];
  logic [7:0] ovf  [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    prog = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0c};
    ovf  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    reset          = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_start   = 1'b0;
    bus.ld_base    = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_byte    = '0;
    bus.ld_last    = 1'b0;
    repeat (3) step();

    check_eq("rst_busy", 64'(bus.busy), 64'd1);
    check_eq("rst_valid", 64'(bus.fetch_valid), 64'd0);
    check_eq("rst_error", 64'(bus.ld_error), 64'd0);
    check_eq("rst_count", 64'(bus.ld_count), 64'd0);
    check_eq("rst_instr", 64'(bus.fetch_instr), 64'd0);

    // Clear lasts exactly Depth cycles, fetch requests ignored meanwhile.
    reset         = 1'b1;
    bus.fetch_req = 1'b1;
    wait_clear("clear_cycles");
    bus.fetch_req = 1'b0;
    step();
    fetch("clr_f5", 6'd5, 32'h0000_0000);

    // Load two words with an idle gap mid-session.
    start_load(6'd0);
    check_eq("ld_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], i == 7);
      if (i == 3) step();
    end
    check_eq("ld_count", 64'(bus.ld_count), 64'd2);
    check_eq("ld_error", 64'(bus.ld_error), 64'd0);
    check_eq("ld_done_busy", 64'(bus.busy), 64'd0);
    fetch("ld_f0", 6'd0, 32'h2002_0005);
    fetch("ld_f1", 6'd1, 32'h2003_000c);  // back-to-back
    step();
    check_eq("idle_valid", 64'(bus.fetch_valid), 64'd0);
    check_eq("hold_instr", 64'(bus.fetch_instr), 64'h2003_000c);

    // Partial word on ld_last.
    start_load(6'd4);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    check_eq("part_error", 64'(bus.ld_error), 64'd1);
    check_eq("part_count", 64'(bus.ld_count), 64'd0);
    check_eq("part_busy", 64'(bus.busy), 64'd0);
    fetch("part_f4", 6'd4, 32'h0000_0000);

    // Overflow past the top: second word dropped, no wrap to address 0.
    start_load(6'd63);
    check_eq("ovf_err_cleared", 64'(bus.ld_error), 64'd0);
    for (int i = 0; i < 8; i++) send_byte(ovf[i], i == 7);
    check_eq("ovf_count", 64'(bus.ld_count), 64'd1);
    check_eq("ovf_error", 64'(bus.ld_error), 64'd1);
    fetch("ovf_f63", 6'd63, 32'h1122_3344);
    fetch("ovf_f0", 6'd0, 32'h2002_0005);

    // ld_start wins over a same-cycle fetch.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd1;
    start_load(6'd10);
    bus.fetch_req = 1'b0;
    check_eq("prio_valid", 64'(bus.fetch_valid), 64'd0);
    check_eq("prio_busy", 64'(bus.busy), 64'd1);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    check_eq("prio_count", 64'(bus.ld_count), 64'd1);
    check_eq("prio_error", 64'(bus.ld_error), 64'd0);
    fetch("prio_f10", 6'd10, 32'hDEAD_BEEF);

    // Reset mid-load, after an error-producing session so ld_error is set.
    start_load(6'd4);
    send_byte(8'h01, 1'b1);
    check_eq("pre_rst_error", 64'(bus.ld_error), 64'd1);
    start_load(6'd0);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    reset = 1'b0;
    repeat (2) step();
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd1);
    check_eq("mid_rst_error", 64'(bus.ld_error), 64'd0);
    reset = 1'b1;
    wait_clear("reclear_cycles");
    fetch("reclr_f0", 6'd0, 32'h0000_0000);
    fetch("reclr_f10", 6'd10, 32'h0000_0000);
    check_eq("reclr_error", 64'(bus.ld_error), 64'd0);
    check_eq("reclr_count", 64'(bus.ld_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
